// File: rtl/cfg_loader_if.sv
// ----------------------------------------------------------------------------
// cfg_loader_if
// Bundles the request, bitstream handshake and fabric-side signals of the
// configuration loader so that the loader and its driver share one port.
//
//   master : drives start, chain_mask, cfg_valid, cfg_data, abort, stop;
//            observes cfg_ready, prog_i, prog_shft, data_en, busy, done
//   slave  : the loader itself (mirror directions)
// ----------------------------------------------------------------------------
interface cfg_loader_if #(
    parameter int CHAINS = 7
);
    logic              start;
    logic [CHAINS-1:0] chain_mask;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [31:0]       cfg_data;
    logic              abort;
    logic              stop;
    logic [31:0]       prog_i;
    logic [CHAINS-1:0] prog_shft;
    logic              data_en;
    logic              busy;
    logic              done;

    modport master (
        output start, chain_mask, cfg_valid, cfg_data, abort, stop,
        input  cfg_ready, prog_i, prog_shft, data_en, busy, done
    );

    modport slave (
        input  start, chain_mask, cfg_valid, cfg_data, abort, stop,
        output cfg_ready, prog_i, prog_shft, data_en, busy, done
    );
endinterface

// File: rtl/cfg_loader.sv
// ----------------------------------------------------------------------------
// cfg_loader
// Streams a configuration bitstream into up to CHAINS fabric shift chains,
// WORDS 32-bit words per chain, lowest selected chain first, with GAP idle
// cycles between chains. After the last chain the fabric user data path is
// enabled (RUN) until stop or abort.
//
// Ports
//   clk   : single clock, all state on rising edge
//   nres  : asynchronous active-low reset
//   bus   : cfg_loader_if.slave
//           start/chain_mask  load request and chain selection
//           cfg_valid/cfg_ready/cfg_data  bitstream word handshake
//           abort/stop        cancel anything / leave RUN
//           prog_i/prog_shft  word and one-hot shift enable to the fabric
//           data_en/busy/done fabric enable, load in progress, completion
// ----------------------------------------------------------------------------
module cfg_loader #(
    parameter int CHAINS = 7,
    parameter int WORDS  = 8,
    parameter int GAP    = 2
) (
    input  logic         clk,
    input  logic         nres,
    cfg_loader_if.slave  bus
);

    localparam int CIDX  = (CHAINS > 1) ? $clog2(CHAINS) : 1;
    localparam int WBITS = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [WBITS-1:0] W_LAST   = WBITS'(WORDS - 1);
    localparam logic [3:0]       GAP_LAST = 4'(GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_GAP  = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CHAINS-1:0] mask_q, mask_d;
    logic [CIDX-1:0]   cur_q, cur_d;
    logic [WBITS-1:0]  wcnt_q, wcnt_d;
    logic [3:0]        gcnt_q, gcnt_d;
    logic [31:0]       prog_q, prog_d;
    logic [CHAINS-1:0] shft_q, shft_d;
    logic              done_q, done_d;

    // Index of the lowest set bit (0 when none is set).
    function automatic logic [CIDX-1:0] lowest_set(input logic [CHAINS-1:0] m);
        logic [CIDX-1:0] idx;
        idx = '0;
        for (int i = CHAINS - 1; i >= 0; i--) begin
            idx = m[i] ? CIDX'(i) : idx;
        end
        return idx;
    endfunction

    // Mask bits strictly above the current chain index.
    function automatic logic [CHAINS-1:0] above(input logic [CHAINS-1:0] m,
                                                input logic [CIDX-1:0]   cur);
        logic [CHAINS-1:0] r;
        for (int i = 0; i < CHAINS; i++) begin
            r[i] = m[i] && (CIDX'(i) > cur);
        end
        return r;
    endfunction

    // One-hot shift enable for a chain index.
    function automatic logic [CHAINS-1:0] onehot(input logic [CIDX-1:0] cur);
        logic [CHAINS-1:0] r;
        for (int i = 0; i < CHAINS; i++) begin
            r[i] = (CIDX'(i) == cur);
        end
        return r;
    endfunction

    // State and datapath registers.
    always_ff @(posedge clk or negedge nres) begin
        if (!nres) begin
            state_q <= ST_IDLE;
            mask_q  <= '0;
            cur_q   <= '0;
            wcnt_q  <= '0;
            gcnt_q  <= 4'd0;
            prog_q  <= 32'd0;
            shft_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            cur_q   <= cur_d;
            wcnt_q  <= wcnt_d;
            gcnt_q  <= gcnt_d;
            prog_q  <= prog_d;
            shft_q  <= shft_d;
            done_q  <= done_d;
        end
    end

    // Next-state and next-datapath logic; abort overrides every state.
    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        cur_d   = cur_q;
        wcnt_d  = wcnt_q;
        gcnt_d  = gcnt_q;
        prog_d  = prog_q;      // prog_i holds across stalls
        shft_d  = '0;          // only a transfer produces a shift
        done_d  = 1'b0;
        if (bus.abort) begin
            state_d = ST_IDLE;
            mask_d  = '0;
            cur_d   = '0;
            wcnt_d  = '0;
            gcnt_d  = 4'd0;
            prog_d  = 32'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        mask_d = bus.chain_mask;
                        wcnt_d = '0;
                        gcnt_d = 4'd0;
                        if (bus.chain_mask == '0) begin
                            state_d = ST_RUN;
                            done_d  = 1'b1;
                        end else begin
                            cur_d   = lowest_set(bus.chain_mask);
                            state_d = ST_LOAD;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    if (bus.cfg_valid) begin
                        prog_d = bus.cfg_data;
                        shft_d = onehot(cur_q);
                        if (wcnt_q == W_LAST) begin
                            wcnt_d = '0;
                            if (|above(mask_q, cur_q)) begin
                                state_d = ST_GAP;
                                gcnt_d  = 4'd0;
                            end else begin
                                state_d = ST_RUN;
                                done_d  = 1'b1;
                            end
                        end else begin
                            wcnt_d = wcnt_q + WBITS'(1);
                        end
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
                ST_GAP: begin
                    // Chain advances only as the gap ends, so prog_shft stays
                    // zero for exactly GAP cycles after the last shift.
                    if (gcnt_q == GAP_LAST) begin
                        gcnt_d  = 4'd0;
                        cur_d   = lowest_set(above(mask_q, cur_q));
                        state_d = ST_LOAD;
                    end else begin
                        gcnt_d = gcnt_q + 4'd1;
                    end
                end
                ST_RUN: begin
                    if (bus.stop) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Output decode; cfg_ready is combinational so a word can move every cycle.
    always_comb begin
        bus.prog_i    = prog_q;
        bus.prog_shft = shft_q;
        bus.done      = done_q;
        bus.cfg_ready = 1'b0;
        bus.data_en   = 1'b0;
        bus.busy      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                bus.busy = 1'b0;
            end
            ST_LOAD: begin
                bus.cfg_ready = !bus.abort;
                bus.busy      = 1'b1;
            end
            ST_GAP: begin
                bus.busy = 1'b1;
            end
            ST_RUN: begin
                bus.data_en = 1'b1;
            end
            default: begin
                bus.busy = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cfg_loader.sv
// ----------------------------------------------------------------------------
// tb_cfg_loader
// Directed bench for cfg_loader (CHAINS=7, WORDS=8, GAP=2). A vector table
// covers the single-cycle behaviour and a stalled single-chain load; the
// multi-chain loads, abort and asynchronous reset use a small schedule model.
// ----------------------------------------------------------------------------
module tb_cfg_loader;

    logic clk;
    logic nres;
    int   n_chk;
    int   n_pass;
    logic [31:0] model_prog;

    cfg_loader_if #(.CHAINS(7)) bus ();

    cfg_loader #(.CHAINS(7), .WORDS(8), .GAP(2)) dut (
        .clk  (clk),
        .nres (nres),
        .bus  (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        start;
        logic [6:0]  mask;
        logic        valid;
        logic [31:0] data;
        logic        abort;
        logic        stop;
        logic        rdy;
        logic [6:0]  shft;
        logic [31:0] prog;
        logic        den;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t vq[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic add(input string nm, input logic st, input logic [6:0] m,
                       input logic v, input logic [31:0] d, input logic ab,
                       input logic sp, input logic rdy, input logic [6:0] sh,
                       input logic [31:0] pr, input logic den, input logic bz,
                       input logic dn);
        vec_t e;
        e.name = nm; e.start = st; e.mask = m; e.valid = v; e.data = d;
        e.abort = ab; e.stop = sp; e.rdy = rdy; e.shft = sh; e.prog = pr;
        e.den = den; e.busy = bz; e.done = dn;
        vq.push_back(e);
    endtask

    task automatic drive_idle();
        bus.start = 1'b0; bus.chain_mask = 7'd0; bus.cfg_valid = 1'b0;
        bus.cfg_data = 32'd0; bus.abort = 1'b0; bus.stop = 1'b0;
    endtask

    // Registered outputs after an edge.
    task automatic chk_outs(input string nm, input logic [6:0] sh, input logic [31:0] pr,
                            input logic den, input logic bz, input logic dn);
        chk({nm, "_shft"}, 32'(bus.prog_shft), 32'(sh));
        chk({nm, "_prog"}, bus.prog_i, pr);
        chk({nm, "_den"},  32'(bus.data_en), 32'(den));
        chk({nm, "_busy"}, 32'(bus.busy), 32'(bz));
        chk({nm, "_done"}, 32'(bus.done), 32'(dn));
    endtask

    // Start a load of mask with words streamed back to back. Chain seg of
    // the selected list transfers in cycles seg*10 .. seg*10+7 (8 words,
    // then 2 gap cycles). Optional abort or async reset at cycle abort_at /
    // rst_at ends the sequence early.
    task automatic run_load(input string nm, input logic [6:0] mask,
                            input int abort_at, input int rst_at);
        int lst[$];
        int n, t_last, cnt, seg, off;
        logic xf;
        logic [6:0] one;
        logic [6:0] exp_sh;
        one = 7'd1;
        for (int i = 0; i < 7; i++) begin
            if (mask[i]) lst.push_back(i);
        end
        n = lst.size();
        t_last = (n - 1) * 10 + 7;
        cnt = 0;
        bus.start = 1'b1; bus.chain_mask = mask;
        #1;
        chk({nm, "_start_rdy"}, 32'(bus.cfg_ready), 32'd0);
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk_outs({nm, "_start"}, 7'd0, model_prog, 1'b0, 1'b1, 1'b0);
        for (int t = 0; t <= t_last + 1; t++) begin
            seg = t / 10;
            off = t % 10;
            xf = (seg < n) && (off < 8) && (t != abort_at);
            bus.cfg_valid  = 1'b1;
            bus.cfg_data   = 32'hF000_0000 + cnt;
            bus.chain_mask = ~mask;          // must not disturb the running load
            bus.abort      = (t == abort_at);
            #1;
            chk($sformatf("%s_t%0d_rdy", nm, t), 32'(bus.cfg_ready), 32'(xf));
            @(posedge clk); #1;
            if (t == abort_at) begin
                bus.abort = 1'b0; bus.cfg_valid = 1'b0;
                model_prog = 32'd0;
                chk_outs($sformatf("%s_abort", nm), 7'd0, 32'd0, 1'b0, 1'b0, 1'b0);
                return;
            end
            if (xf) begin
                exp_sh = one << lst[seg];
                model_prog = 32'hF000_0000 + cnt;
                cnt++;
            end else begin
                exp_sh = 7'd0;
            end
            chk_outs($sformatf("%s_t%0d", nm, t), exp_sh, model_prog,
                     (t >= t_last), (t < t_last), (t == t_last));
            if (t == rst_at) begin
                bus.cfg_valid = 1'b0;
                #2;
                nres = 1'b0;
                #1;
                model_prog = 32'd0;
                chk(nm, 32'(bus.cfg_ready), 32'd0);
                chk_outs({nm, "_async_rst"}, 7'd0, 32'd0, 1'b0, 1'b0, 1'b0);
                #2;
                nres = 1'b1;
                @(posedge clk); #1;
                chk_outs({nm, "_after_rst"}, 7'd0, 32'd0, 1'b0, 1'b0, 1'b0);
                return;
            end
        end
        bus.cfg_valid = 1'b0;
    endtask

    initial begin
        vec_t v;
        logic vld;
        logic [31:0] d;
        n_chk = 0;
        n_pass = 0;
        model_prog = 32'd0;

        // name, start, mask, valid, data, abort, stop | rdy, shft, prog, den, busy, done
        add("idle",        1'b0, 7'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b0, 1'b0);
        add("stop_idle",   1'b0, 7'h00, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 7'h00, 32'h0, 1'b0, 1'b0, 1'b0);
        add("start_mask0", 1'b1, 7'h00, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 7'h00, 32'h0, 1'b1, 1'b0, 1'b1);
        add("run_hold",    1'b1, 7'h7F, 1'b1, 32'h5, 1'b0, 1'b0, 1'b0, 7'h00, 32'h0, 1'b1, 1'b0, 1'b0);
        add("run_stop",    1'b0, 7'h00, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 7'h00, 32'h0, 1'b0, 1'b0, 1'b0);
        add("abort_start", 1'b1, 7'h01, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b0, 1'b0);
        add("start_m01",   1'b1, 7'h01, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b1, 1'b0);
        // Stalled load of chain 0: valid on even cycles only, 8th transfer at i=14.
        for (int i = 0; i < 16; i++) begin
            vld = (i % 2 == 0);
            d = 32'hA000_0000 + i;
            if (i < 15) begin
                add($sformatf("stall%0d", i), (i == 3), 7'h7F, vld, d, 1'b0, 1'b0,
                    1'b1, vld ? 7'h01 : 7'h00,
                    vld ? d : (32'hA000_0000 + i - 1),
                    (i == 14), (i < 14), (i == 14));
            end else begin
                add($sformatf("stall%0d", i), 1'b0, 7'h7F, vld, d, 1'b0, 1'b0,
                    1'b0, 7'h00, 32'hA000_000E, 1'b1, 1'b0, 1'b0);
            end
        end
        add("stop_run",    1'b0, 7'h00, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 7'h00, 32'hA000_000E, 1'b0, 1'b0, 1'b0);
        add("abort_idle",  1'b0, 7'h00, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 7'h00, 32'h0, 1'b0, 1'b0, 1'b0);

        drive_idle();
        nres = 1'b0;
        #12;
        chk_outs("reset", 7'd0, 32'd0, 1'b0, 1'b0, 1'b0);
        chk("reset_rdy", 32'(bus.cfg_ready), 32'd0);
        @(negedge clk);
        nres = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < vq.size(); k++) begin
            v = vq[k];
            bus.start = v.start; bus.chain_mask = v.mask; bus.cfg_valid = v.valid;
            bus.cfg_data = v.data; bus.abort = v.abort; bus.stop = v.stop;
            #1;
            chk({v.name, "_rdy"}, 32'(bus.cfg_ready), 32'(v.rdy));
            @(posedge clk); #1;
            chk_outs(v.name, v.shft, v.prog, v.den, v.busy, v.done);
        end
        drive_idle();
        model_prog = 32'd0;

        // Full load of all chains, then stop.
        run_load("full", 7'h7F, -1, -1);
        bus.stop = 1'b1;
        @(posedge clk); #1;
        bus.stop = 1'b0;
        chk_outs("full_stop", 7'd0, model_prog, 1'b0, 1'b0, 1'b0);

        // Sparse mask: chains 1 and 4 only.
        run_load("sparse", 7'h12, -1, -1);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        model_prog = 32'd0;
        chk_outs("sparse_abort", 7'd0, 32'd0, 1'b0, 1'b0, 1'b0);

        // Abort after the 3rd word of chain 2, then reload starts at chain 1.
        run_load("abort", 7'h07, 23, -1);
        run_load("reload", 7'h06, 1, -1);

        // Asynchronous reset in the gap, then a full reload from chain 0.
        run_load("rstgap", 7'h03, -1, 8);
        run_load("post_rst", 7'h03, -1, -1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cfg_loader.md
CFG_LOADER -- requirements
Module: cfg_loader

Interface
REQ-001 Parameter: CHAINS, default 7, number of configuration shift chains (width of prog_shft).
REQ-002 Parameter: WORDS, default 8, 32-bit words per chain.
REQ-003 Parameter: GAP, default 2, idle cycles between chains (1..15).
REQ-004 Port: clk  in  1  single clock, all state on rising edge.
REQ-005 Port: nres  in  1  reset, asynchronous, active-low.
REQ-006 Port: start  in  1  one-cycle request to begin a load; ignored unless IDLE.
REQ-007 Port: chain_mask  in  CHAINS  chains to load, sampled on accepted start.
REQ-008 Port: cfg_valid / cfg_ready  in / out  1 / 1  bitstream word handshake.
REQ-009 Port: cfg_data  in  32  bitstream word.
REQ-010 Port: abort  in  1  cancels load or run, highest priority after reset.
REQ-011 Port: stop  in  1  ends RUN state.
REQ-012 Port: prog_i  out  32  word presented to the fabric.
REQ-013 Port: prog_shft  out  CHAINS  one-hot shift enable for the active chain, zero otherwise.
REQ-014 Port: data_en  out  1  fabric user-data enable.
REQ-015 Port: busy / done  out / out  1 / 1  load in progress / one-cycle completion pulse.

Function
REQ-016 States SHALL be IDLE, LOAD, GAP, RUN; transitions only on rising clk.
REQ-017 IDLE: cfg_ready=0, prog_shft=0, data_en=0; start=1 latches chain_mask, selects lowest set bit as current chain, goes to LOAD.
REQ-018 start with chain_mask=0 SHALL go directly to RUN, pulsing done for one cycle.
REQ-019 LOAD: cfg_ready=1 combinationally; a transfer occurs when cfg_valid&cfg_ready.
REQ-020 On a transfer, next cycle prog_i=cfg_data and prog_shft=one-hot(current chain); latency exactly one cycle.
REQ-021 Cycle after a non-transfer cycle, prog_shft SHALL be 0 and prog_i SHALL hold its last value (stall, no fabric shift).
REQ-022 Word counter (clog2(WORDS) bits) increments per transfer; the WORDS-th transfer clears it and leaves LOAD.
REQ-023 After last word: if a higher set mask bit remains, go to GAP; else go to RUN and pulse done.
REQ-024 GAP: cfg_ready=0, prog_shft=0 for exactly GAP cycles, then current chain advances to next set mask bit (ascending), back to LOAD.
REQ-025 RUN: data_en=1, cfg_ready=0, prog_shft=0; stop=1 returns to IDLE with data_en=0 next cycle.
REQ-026 busy=1 in LOAD and GAP, 0 in IDLE and RUN.
REQ-027 done SHALL assert for exactly one cycle, concurrent with the first RUN cycle.
REQ-028 abort=1 in any state: next cycle IDLE, prog_shft=0, prog_i=0, data_en=0, counters cleared, no done pulse; a transfer offered in the abort cycle is not accepted (cfg_ready=0 when abort=1).
REQ-029 abort and start in same cycle: abort wins, stays IDLE.
REQ-030 start while not IDLE, and stop outside RUN, SHALL be ignored.
REQ-031 chain_mask changes after start SHALL not affect the load in progress.

Reset
REQ-032 nres=0 SHALL immediately force IDLE, prog_i=0, prog_shft=0, data_en=0, cfg_ready=0, busy=0, done=0, counters and latched mask 0, regardless of clk.
REQ-033 Reset deassertion SHALL take effect on the next rising clk; reset mid-LOAD discards partial chain.

Verification
REQ-034 Full load: mask=7'h7F, 56 back-to-back words 32'hF0000000.. -> prog_shft 01 for 8 cycles, 0 for GAP, 02 ... 40; done one pulse; data_en=1.
REQ-035 Stall: mask=7'h01, cfg_valid toggling 1/0 -> prog_shft 01 only in cycles after transfers, prog_i holds during gaps, 8 shifts total.
REQ-036 Sparse mask 7'h12 -> only prog_shft 02 then 10 bursts of 8; mask=0 -> RUN and done in cycle after start, no prog_shft.
REQ-037 abort after 3rd word of chain 2 -> next cycle IDLE, all outputs 0, no done; subsequent start reloads from lowest mask bit.
REQ-038 nres low mid-GAP, asynchronous to clk -> outputs 0 before next edge; stop in RUN -> data_en 0 next cycle.
